// File: rtl/yuv_gpif_packer.sv
// Buffers 64-bit YUV422 words in a small FIFO and re-emits them as 32-bit words
// (upper pixel pair first) on a valid/ready stream with frame-start and line-end markers.
module yuv_gpif_packer #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned LINE_WORDS      = 480
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       frame_start_i,
    input  logic [63:0]                yuv_i,
    input  logic                       yuv_valid_i,
    output logic [31:0]                data_o,
    output logic                       data_valid_o,
    input  logic                       data_ready_i,
    output logic                       frame_start_o,
    output logic                       line_end_o,
    output logic                       overflow_o,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level_o
);

    localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;

    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t        DepthCnt = cnt_t'(Depth);
    localparam logic [15:0] LastIdx  = 16'(LINE_WORDS - 1);

    // Entry layout: [65] sof tag, [64] eol tag, [63:0] pixel data.
    logic [65:0] mem_q [Depth];

    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    logic        half_q, half_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        sof_pending_q, sof_pending_d;
    logic        overflow_q, overflow_d;

    logic [65:0] head;
    logic [65:0] entry;
    logic [15:0] line_idx;
    logic        valid;
    logic        full;
    logic        xfer;
    logic        pop;
    logic        wr_en;
    logic        drop;

    always_comb begin
        head     = mem_q[rd_ptr_q];
        valid    = (count_q != '0);
        full     = (count_q == DepthCnt);
        xfer     = valid & data_ready_i;
        pop      = xfer & half_q;
        wr_en    = yuv_valid_i & (~full | pop);
        drop     = yuv_valid_i & ~wr_en;
        line_idx = frame_start_i ? 16'd0 : line_cnt_q;
        entry    = {frame_start_i | sof_pending_q, line_idx == LastIdx, yuv_i};
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        half_d        = half_q;
        line_cnt_d    = line_cnt_q;
        sof_pending_d = sof_pending_q;
        overflow_d    = overflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (xfer) begin
            half_d = ~half_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase

        // Dropped words still advance the counter so line alignment survives overflow.
        if (yuv_valid_i) begin
            line_cnt_d    = (line_idx == LastIdx) ? 16'd0 : line_idx + 16'd1;
            sof_pending_d = 1'b0;
        end else if (frame_start_i) begin
            line_cnt_d    = 16'd0;
            sof_pending_d = 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (frame_start_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            half_q        <= 1'b0;
            line_cnt_q    <= '0;
            sof_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            half_q        <= half_d;
            line_cnt_q    <= line_cnt_d;
            sof_pending_q <= sof_pending_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage needs no reset: outputs are gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (!reset_i && wr_en) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    always_comb begin
        data_valid_o  = valid;
        data_o        = valid ? (half_q ? head[31:0] : head[63:32]) : 32'd0;
        frame_start_o = valid & head[65] & ~half_q;
        line_end_o    = valid & head[64] & half_q;
        overflow_o    = overflow_q;
        fifo_level_o  = count_q;
    end

endmodule

// File: tb/tb_yuv_gpif_packer.sv
// Self-checking bench for yuv_gpif_packer: table-driven frames plus a scoreboard of
// expected 32-bit words, with hand-written sequences for overflow, back-pressure and reset.
module tb_yuv_gpif_packer;

    localparam int unsigned DepthLog2 = 4;

    logic                 clk;
    logic                 reset_i;
    logic                 frame_start_i;
    logic [63:0]          yuv_i;
    logic                 yuv_valid_i;
    logic [31:0]          data_o;
    logic                 data_valid_o;
    logic                 data_ready_i;
    logic                 frame_start_o;
    logic                 line_end_o;
    logic                 overflow_o;
    logic [DepthLog2:0]   fifo_level_o;

    yuv_gpif_packer #(
        .FIFO_DEPTH_LOG2 (DepthLog2),
        .LINE_WORDS      (4)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .frame_start_i (frame_start_i),
        .yuv_i         (yuv_i),
        .yuv_valid_i   (yuv_valid_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .data_ready_i  (data_ready_i),
        .frame_start_o (frame_start_o),
        .line_end_o    (line_end_o),
        .overflow_o    (overflow_o),
        .fifo_level_o  (fifo_level_o)
    );

    typedef struct {
        logic        fs;
        logic        v;
        logic [63:0] yuv;
        logic        sof;
        logic        eol;
        logic        drop;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] exp_q[$];
    logic        toggle  = 1'b0;
    logic        mon_en  = 1'b0;
    logic        hold    = 1'b0;
    logic [33:0] last_out;
    vec_t        t1[4];
    vec_t        t6[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle) data_ready_i = ~data_ready_i;
    endtask

    task automatic drive(input logic fs, input logic v, input logic [63:0] d,
                         input logic sof, input logic eol, input logic drop);
        frame_start_i = fs;
        yuv_valid_i   = v;
        yuv_i         = d;
        if (v && !drop) begin
            exp_q.push_back({d[63:32], sof, 1'b0});
            exp_q.push_back({d[31:0], 1'b0, eol});
        end
        tick();
        frame_start_i = 1'b0;
        yuv_valid_i   = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        drive(v.fs, v.v, v.yuv, v.sof, v.eol, v.drop);
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && !(exp_q.size() == 0 && !data_valid_o); c++) tick();
        check("drain_done", {62'd0, exp_q.size() == 0, data_valid_o}, 64'h2);
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && !reset_i) begin
            if (hold) check("hold_stable", {30'd0, data_o, frame_start_o, line_end_o},
                            {30'd0, last_out});
            if (data_valid_o && data_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, expected no transfer", data_o);
                end else begin
                    check("stream_word", {30'd0, data_o, frame_start_o, line_end_o},
                          {30'd0, exp_q.pop_front()});
                end
            end
            hold     = data_valid_o && !data_ready_i;
            last_out = {data_o, frame_start_o, line_end_o};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        t1[0] = '{1'b1, 1'b1, 64'h11111111_22222222, 1'b1, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b1, 64'h33333333_44444444, 1'b0, 1'b0, 1'b0};
        t1[2] = '{1'b0, 1'b1, 64'h55555555_66666666, 1'b0, 1'b0, 1'b0};
        t1[3] = '{1'b0, 1'b1, 64'h77777777_88888888, 1'b0, 1'b1, 1'b0};
        t6[0] = '{1'b1, 1'b1, 64'hC0C0C0C0_D0D0D0D0, 1'b1, 1'b0, 1'b0};
        t6[1] = '{1'b0, 1'b1, 64'hC1C1C1C1_D1D1D1D1, 1'b0, 1'b0, 1'b0};
        t6[2] = '{1'b0, 1'b1, 64'hC2C2C2C2_D2D2D2D2, 1'b0, 1'b0, 1'b0};
        t6[3] = '{1'b0, 1'b1, 64'hC3C3C3C3_D3D3D3D3, 1'b0, 1'b1, 1'b0};

        reset_i       = 1'b1;
        frame_start_i = 1'b0;
        yuv_i         = '0;
        yuv_valid_i   = 1'b0;
        data_ready_i  = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        check("reset_outputs", {data_o, data_valid_o, frame_start_o, line_end_o, overflow_o,
                                fifo_level_o}, 64'd0);
        mon_en = 1'b1;

        // 1: basic frame, first output one cycle after the first write
        apply(t1[0]);
        check("first_latency", {31'd0, data_valid_o, data_o}, {31'd0, 1'b1, 32'h11111111});
        check("first_sof", {63'd0, frame_start_o}, 64'd1);
        for (int i = 1; i < 4; i++) apply(t1[i]);
        drain();

        // 2: fill with ready low, then overflow, then frame start clears it
        data_ready_i = 1'b0;
        for (int i = 0; i < 16; i++)
            drive(i == 0, 1'b1, {32'hA0000000 + i, 32'hB0000000 + i}, i == 0, i % 4 == 3, 1'b0);
        check("full_level", {59'd0, fifo_level_o}, 64'd16);
        check("full_no_ovf", {63'd0, overflow_o}, 64'd0);
        drive(1'b0, 1'b1, 64'hDEADBEEF_DEADBEEF, 1'b0, 1'b0, 1'b1);
        check("ovf_set", {63'd0, overflow_o}, 64'd1);
        check("ovf_level", {59'd0, fifo_level_o}, 64'd16);
        check("ovf_data_held", {32'd0, data_o}, {32'd0, 32'hA0000000});
        drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("ovf_cleared", {63'd0, overflow_o}, 64'd0);

        // 3: full, h=1, ready high, concurrent write is accepted
        data_ready_i = 1'b1;
        tick();
        check("h1_lower_half", {32'd0, data_o}, {32'd0, 32'hB0000000});
        drive(1'b0, 1'b1, 64'hE0E0E0E0_F0F0F0F0, 1'b1, 1'b0, 1'b0);
        check("popwrite_level", {59'd0, fifo_level_o}, 64'd16);
        check("popwrite_no_ovf", {63'd0, overflow_o}, 64'd0);
        drain();

        // 4: ready toggling every cycle
        data_ready_i = 1'b0;
        toggle       = 1'b1;
        for (int i = 0; i < 8; i++)
            drive(i == 0, 1'b1, {32'h40000000 + i, 32'h50000000 + i}, i == 0, i % 4 == 3, 1'b0);
        drain();
        toggle       = 1'b0;
        data_ready_i = 1'b1;

        // 5: deferred sof, and a drop mid-line still advances line-end placement
        data_ready_i = 1'b0;
        drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("idle_level", {59'd0, fifo_level_o}, 64'd0);
        for (int k = 0; k < 16; k++)
            drive(1'b0, 1'b1, {32'h60000000 + k, 32'h70000000 + k}, k == 0, k % 4 == 3, 1'b0);
        drive(1'b0, 1'b1, 64'h66666666_77777777, 1'b0, 1'b0, 1'b1);
        check("t5_ovf", {63'd0, overflow_o}, 64'd1);
        data_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int k = 17; k < 20; k++)
            drive(1'b0, 1'b1, {32'h60000000 + k, 32'h70000000 + k}, 1'b0, k == 19, 1'b0);
        drain();
        check("t5_ovf_sticky", {63'd0, overflow_o}, 64'd1);

        // 6: reset mid-stream with h=1 and a word presented in the reset cycle
        data_ready_i = 1'b0;
        for (int i = 0; i < 5; i++)
            drive(i == 0, 1'b1, {32'h90000000 + i, 32'hA5000000 + i}, i == 0, i == 3, 1'b0);
        data_ready_i = 1'b1;
        tick();
        reset_i     = 1'b1;
        yuv_valid_i = 1'b1;
        yuv_i       = 64'h12345678_9ABCDEF0;
        @(posedge clk);
        #1;
        reset_i     = 1'b0;
        yuv_valid_i = 1'b0;
        exp_q.delete();
        check("midreset_outputs", {data_o, data_valid_o, frame_start_o, line_end_o, overflow_o,
                                   fifo_level_o}, 64'd0);
        for (int i = 0; i < 4; i++) apply(t6[i]);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/yuv_gpif_packer.md
# yuv_gpif_packer

Downstream neighbour of the RGB-to-YUV converter. Accepts 64-bit, 4-pixel YUV422 words (qualified by a valid strobe, no back-pressure) and buffers them in a small FIFO. It re-emits them as 32-bit words on a valid/ready stream toward the USB3 GPIF output stage, tagging each word with frame-start and line-end markers. Overflow is detected and flagged because the upstream pipeline cannot stall.

## Interface
- FIFO_DEPTH_LOG2, 4: FIFO holds 2^FIFO_DEPTH_LOG2 64-bit entries (16).
- LINE_WORDS, 480: 64-bit input words per video line (1920 px / 4); range 1..65535.
- clk_i  in  1  single clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- frame_start_i  in  1  one-cycle pulse marking start of a new frame.
- yuv_i  in  64  {Y0,U0,Y1,V0, Y2,U2,Y3,V2}, 8 bits each, MSB first.
- yuv_valid_i  in  1  yuv_i valid this cycle; no ready returned.
- data_o  out  32  output word.
- data_valid_o  out  1  data_o valid.
- data_ready_i  in  1  consumer accepts data_o when high with data_valid_o.
- frame_start_o  out  1  high with the first 32-bit word of a frame.
- line_end_o  out  1  high with the last 32-bit word of a line.
- overflow_o  out  1  sticky: an input word was dropped.
- fifo_level_o  out  FIFO_DEPTH_LOG2+1  occupied entries, 0..2^FIFO_DEPTH_LOG2.

## Operation
- Entry format: {sof_tag, eol_tag, yuv_i[63:0]}.
- Write: when yuv_valid_i=1 and (level < depth, or a pop occurs the same cycle). Otherwise the word is dropped and overflow_o is set.
- overflow_o clears only on reset_i or frame_start_i. If frame_start_i and a drop occur in the same cycle, the set wins.
- Line counter (16 bit) increments per accepted or dropped valid input word and wraps LINE_WORDS-1 -> 0. eol_tag=1 when the counter equals LINE_WORDS-1. Dropped words still advance the counter so line alignment is preserved.
- frame_start_i: the line counter is forced to 0 and sof_pending is set.
  - If yuv_valid_i is high the same cycle, that word is counter index 0 and carries sof_tag=1, and sof_pending stays clear.
  - Otherwise the next valid word carries sof_tag=1 and clears sof_pending.
  - A second frame_start_i before any word is harmless.
- Output (show-ahead): data_valid_o = (level != 0). A half-select bit h selects data_o = h ? head[31:0] : head[63:32], so the upper pixel pair goes first.
  - frame_start_o = head.sof_tag & ~h.
  - line_end_o = head.eol_tag & h.
  - Both markers are 0 when data_valid_o=0.
- Handshake: a transfer happens when data_valid_o & data_ready_i. On a transfer with h=0, h becomes 1. On a transfer with h=1, h becomes 0 and the head entry is popped.
- data_o and the marker outputs must hold stable while data_valid_o=1 and data_ready_i=0.
- fifo_level_o = level after the current edge. Simultaneous write and pop leave the level unchanged.
- Pointers wrap modulo depth. Full/empty are derived from a (FIFO_DEPTH_LOG2+1)-bit count.

## Timing
- Reset values:
  - data_o=0, data_valid_o=0, frame_start_o=0, line_end_o=0, overflow_o=0, fifo_level_o=0.
  - Internal: h=0, pointers 0, line counter 0, sof_pending 0.
- Asserting reset_i mid-stream discards all FIFO contents and any half-sent entry. An input word in the reset cycle is not written.
- Latency: an entry written at edge N into an empty FIFO shows on data_o with data_valid_o=1 after edge N, i.e. in cycle N+1.
- Throughput: 2 output cycles per input word. The input may average at most one valid word per two cycles over any window longer than the buffer; bursts up to depth+1 words are lossless with continuous ready.
- Markers are combinational from registered state (head entry, h). There are no combinational paths from data_ready_i to data_valid_o.

## Test plan
1. Reset, then LINE_WORDS=4. Pulse frame_start_i together with the first of 4 valid words 0x1111111122222222, 0x33..44, 0x55..66, 0x77..88, with data_ready_i=1.
   - Required: data_o sequence 0x11111111, 0x22222222, … 0x88888888.
   - frame_start_o only on 0x11111111; line_end_o only on 0x88888888.
   - First valid output appears one cycle after the first write.
2. data_ready_i=0, then 16 valid words.
   - Required: fifo_level_o=16, overflow_o=0.
   - A 17th word: overflow_o=1, level stays 16, data_o unchanged.
   - Then frame_start_i: overflow_o=0.
3. Full FIFO with data_ready_i=1, h=1, plus a simultaneous valid input.
   - Required: write accepted, level stays 16, overflow_o=0.
4. Back-pressure: toggle data_ready_i every cycle over an 8-word stream.
   - Required: no duplicated or lost 32-bit words; data_o stable on every ready=0 cycle.
5. frame_start_i with no valid input, idle 3 cycles, then a word.
   - Required: that word gets frame_start_o on its upper half and line counter index 0.
   - A dropped word mid-line still advances line_end_o placement.
6. Assert reset_i after 5 words buffered and h=1.
   - Required: the next cycle shows all outputs 0 and fifo_level_o=0. The next frame streams correctly.
